// File: rtl/demux_14_tdm.sv
// demux_14_tdm: receive side of a 4:1 TDM link, splitting the serial sample stream onto lanes a..d.
// Optional build macro DEMUX_FRAME_CNT_EN adds an 8-bit completed-frame counter port frame_cnt.
module demux_14_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
`ifdef DEMUX_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [1:0]       sel_reg;
  logic             locked_reg;
  logic             frame_valid_reg;
  logic             sync_err_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] d_reg;

  // Decoded events for the current cycle; all are qualified by in_valid.
  logic       slot0_load;
  logic       mid_store;
  logic       frame_done;
  logic       early_err;
  logic       miss_err;
  logic [2:0] shadow_we;

  logic [WIDTH-1:0] shadow [3];

  always_comb begin
    slot0_load = 1'b0;
    mid_store  = 1'b0;
    frame_done = 1'b0;
    early_err  = 1'b0;
    miss_err   = 1'b0;
    if (in_valid) begin
      if (frame_sync) begin
        slot0_load = 1'b1;
        early_err  = (state_reg == RUN) && (sel_reg != 2'd0);
      end else if (state_reg == RUN) begin
        if (sel_reg == 2'd0) begin
          miss_err = 1'b1;
        end else if (sel_reg == 2'd3) begin
          frame_done = 1'b1;
        end else begin
          mid_store = 1'b1;
        end
      end
    end
  end

  // Slot 3 never needs a shadow: it goes straight to lane d on completion.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      logic [WIDTH-1:0] shadow_reg;

      if (gi == 0) begin : g_we0
        assign shadow_we[gi] = slot0_load;
      end else begin : g_wen
        assign shadow_we[gi] = mid_store && (sel_reg == 2'(gi));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
        end else if (shadow_we[gi]) begin
          shadow_reg <= in_data;
        end
      end

      assign shadow[gi] = shadow_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      sel_reg         <= 2'd0;
      locked_reg      <= 1'b0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      frame_valid_reg <= frame_done;
      sync_err_reg    <= early_err || miss_err;
      if (slot0_load) begin
        state_reg  <= RUN;
        locked_reg <= 1'b1;
        sel_reg    <= 2'd1;
      end else if (miss_err) begin
        state_reg  <= HUNT;
        locked_reg <= 1'b0;
        sel_reg    <= 2'd0;
      end else if (frame_done || mid_store) begin
        sel_reg <= sel_reg + 2'd1;
      end
    end
  end

  // Lanes move together, only when a full frame has been collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      d_reg <= '0;
    end else if (frame_done) begin
      a_reg <= shadow[0];
      b_reg <= shadow[1];
      c_reg <= shadow[2];
      d_reg <= in_data;
    end
  end

`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= 8'd0;
    end else if (frame_done) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign a           = a_reg;
  assign b           = b_reg;
  assign c           = c_reg;
  assign d           = d_reg;
  assign sel         = sel_reg;
  assign locked      = locked_reg;
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;

endmodule
